iob_sp_ram_arb: RTL and testbench
=================================

Name: iob_sp_ram_arb

Overview:
- Arbiter/sequencer that shares one single-port RAM (en/we/addr/din/dout, 1-cycle registered read) between N_REQ requesters.
- Each requester uses a valid/ready native handshake.
- Sits between the cache's tag/data controllers (or a cache front-end plus a debug/init port) and the RAM instance.
- Serialises accesses and returns read data to the granted requester only.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- ADDR_W, 14, RAM address width.
- DATA_W, 8, RAM data width.

Ports:
- clk  input  1  clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  N_REQ  per-requester access request; held high until matching req_ready pulse.
- req_we  input  N_REQ  per-requester: 1 = write, 0 = read.
- req_addr  input  N_REQ*ADDR_W  flattened addresses; requester i at [i*ADDR_W +: ADDR_W].
- req_wdata  input  N_REQ*DATA_W  flattened write data; same packing.
- req_ready  output  N_REQ  one-cycle completion pulse, at most one bit set.
- req_rdata  output  DATA_W  read data, valid while the matching req_ready bit is high.
- ram_en  output  1  RAM enable.
- ram_we  output  1  RAM write enable.
- ram_addr  output  ADDR_W  RAM address.
- ram_din  output  DATA_W  RAM write data.
- ram_dout  input  DATA_W  RAM read data, valid one cycle after ram_en with ram_we=0.

Behaviour:
- Clock/reset: one clock; reset is synchronous and active-high.
- Reset values: state=IDLE, req_ready=0, req_rdata=0, grant=0, rr_ptr=0.
- ram_en/ram_we: 0 whenever state != IDLE or there is no request. ram_addr/ram_din: don't-care while ram_en=0.

FSM has two states:
- IDLE:
  - If req_valid != 0, select winner w combinationally.
  - Drive ram_en=1, ram_we=req_we[w], ram_addr/ram_din from requester w in the same cycle.
  - Register grant=w; go to BUSY.
  - If no request: stay IDLE, ram_en=0.
- BUSY:
  - ram_en=0.
  - Registered outputs at the next edge: req_ready[grant]=1 for exactly one cycle; req_rdata=ram_dout for reads, previous value held for writes.
  - rr_ptr = (grant+1) mod N_REQ.
  - Return to IDLE.

Timing and throughput:
- Latency: valid sampled at cycle N (IDLE) → req_ready/req_rdata visible at cycle N+2.
- Throughput: one access per 2 cycles. Requester must drop valid, or present a new request, in the cycle after it sees ready.

Round-robin selection:
- Winner is the first set bit of req_valid, scanning from rr_ptr upward with wrap at N_REQ-1 → 0.
- rr_ptr advances only on completion.

Boundary conditions:
- Simultaneous valids: exactly one grant. The others wait with no ready and no RAM activity on their behalf.
- Valid deasserted while BUSY: protocol violation. Access still completes and the ready pulse still fires.
- Reset while BUSY: access abandoned, no ready pulse, rr_ptr=0. The RAM write may already be committed.
- Single requester active continuously: served every 2 cycles, no bubbles beyond that.
- Starvation bound: a requester with valid held waits at most N_REQ-1 other accesses.

Optional Feature:
- Macro: IOB_SP_RAM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins. rr_ptr is removed and requester 0 can starve the others.
- Undefined: round-robin as specified above.
- All other timing is identical in both modes.

Decomposition:
- Shared package (iob_sp_ram_arb_pkg):
  - state encoding localparams ST_IDLE=1'b0, ST_BUSY=1'b1.
  - Index width constant IDX_W=$clog2(N_REQ), minimum 1.
- Natural sub-module: iob_rr_arb.
  - Pure grant logic: req vector + rr_ptr → one-hot grant + index.
  - Reused by other cache arbiters.
  - The top holds the FSM, grant/rr registers, datapath muxes and response registers.

Test Plan:
- Single read: preload ram[0x010]=0xA5; requester 0 reads 0x010 → ram_en=1, ram_we=0 at cycle 1; req_ready=2'b01 and req_rdata=0xA5 at cycle 3; no further ram_en.
- Write then read: requester 1 writes 0x3C to addr 0x1FFF, then reads 0x1FFF → first req_ready=2'b10, read returns 0x3C; req_rdata holds its old value during the write completion.
- Contention: both valid from reset, requester 0 reads 0x001 (=0x11), requester 1 reads 0x002 (=0x22) → grants 0,1,0,1 alternating; ready pulses 2 cycles apart with rdata 0x11/0x22 matching.
- Fixed-priority build (IOB_SP_RAM_ARB_FIXED_PRIO_EN) with the same stimulus → requester 0 served every access; requester 1 never sees ready while requester 0 stays valid.
- Reset mid-access: assert reset in the BUSY cycle of a requester 1 read → no req_ready pulse; after reset with both valid, requester 0 granted first.
- Idle check: req_valid=0 for 20 cycles → ram_en=0 and req_ready=0 throughout.

Source files
------------

// File: rtl/iob_sp_ram_arb_pkg.sv
// -----------------------------------------------------------------------------
// iob_sp_ram_arb_pkg
// Shared definitions for the single-port RAM arbiter:
//   state_t : two-state sequencer encoding (ST_IDLE = 0, ST_BUSY = 1)
//   idx_w() : width of a requester index, $clog2(n) but never below 1
// -----------------------------------------------------------------------------
package iob_sp_ram_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/iob_sp_ram_arb_if.sv
// -----------------------------------------------------------------------------
// iob_sp_ram_arb_if
// Bundle of the requester-side valid/ready bus and the RAM-side port.
//   req_valid/req_we/req_addr/req_wdata : requests, addresses and data packed
//                                          per requester ([i*W +: W])
//   req_ready/req_rdata                 : one-cycle completion pulse + data
//   ram_en/ram_we/ram_addr/ram_din      : RAM command
//   ram_dout                            : RAM read data (one cycle after en)
// Modports:
//   slave  : the arbiter
//   master : the environment (requesters and the RAM instance)
// -----------------------------------------------------------------------------
interface iob_sp_ram_arb_if #(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8
);
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_we;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*DATA_W-1:0] req_wdata;
  logic [N_REQ-1:0]        req_ready;
  logic [DATA_W-1:0]       req_rdata;
  logic                    ram_en;
  logic                    ram_we;
  logic [ADDR_W-1:0]       ram_addr;
  logic [DATA_W-1:0]       ram_din;
  logic [DATA_W-1:0]       ram_dout;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, ram_dout,
    output req_ready, req_rdata, ram_en, ram_we, ram_addr, ram_din
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, ram_dout,
    input  req_ready, req_rdata, ram_en, ram_we, ram_addr, ram_din
  );
endinterface

// File: rtl/iob_rr_arb.sv
// -----------------------------------------------------------------------------
// iob_rr_arb
// Purely combinational round-robin grant logic.
//   req       : request vector
//   ptr       : index with the highest priority this cycle
//   gnt_oh    : one-hot grant (all zero when no request)
//   gnt_idx   : index of the granted requester (0 when no request)
//   gnt_valid : at least one request present
// The winner is the first set bit of req scanning upward from ptr, wrapping
// from N_REQ-1 to 0. Tying ptr to zero gives fixed lowest-index priority.
// -----------------------------------------------------------------------------
module iob_rr_arb #(
  parameter int N_REQ = 2,
  parameter int IDX_W = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt_oh,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid
);

  // Candidate index at each distance from ptr, already wrapped into range.
  logic [IDX_W-1:0] cand_idx [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
    assign cand_idx[gi] = IDX_W'((int'(ptr) + gi) % N_REQ);
  end

  always_comb begin
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    // Scan from the farthest candidate down so the nearest one to ptr
    // is the last to assign and therefore wins.
    for (int off = N_REQ - 1; off >= 0; off--) begin
      if (req[cand_idx[off]]) begin
        gnt_idx   = cand_idx[off];
        gnt_valid = 1'b1;
      end
    end
    gnt_oh          = '0;
    gnt_oh[gnt_idx] = gnt_valid;
  end

endmodule

// File: rtl/iob_sp_ram_arb.sv
// -----------------------------------------------------------------------------
// iob_sp_ram_arb
// Shares one single-port RAM (1-cycle registered read) between N_REQ
// valid/ready requesters. One access every two cycles: the IDLE cycle issues
// the RAM command for the winner, the BUSY cycle captures read data, and the
// completion (req_ready pulse + req_rdata) is registered out after BUSY.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous, active-high
//   bus   : iob_sp_ram_arb_if.slave (requester bus and RAM port)
// Build option:
//   IOB_SP_RAM_ARB_FIXED_PRIO_EN defined   -> fixed priority, index 0 highest,
//                                             no round-robin pointer
//   IOB_SP_RAM_ARB_FIXED_PRIO_EN undefined -> round-robin, pointer advances
//                                             to grant+1 on each completion
// -----------------------------------------------------------------------------
module iob_sp_ram_arb
  import iob_sp_ram_arb_pkg::*;
#(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  iob_sp_ram_arb_if.slave      bus
);

  localparam int IDX_W = idx_w(N_REQ);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  grant_q, grant_d;
  logic              we_q, we_d;
  logic [N_REQ-1:0]  ready_q, ready_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [N_REQ-1:0]  gnt_oh;
  logic [IDX_W-1:0]  gnt_idx;
  logic              gnt_valid;
  logic [IDX_W-1:0]  arb_ptr;

  // Per-requester views of the packed address/data buses.
  logic [ADDR_W-1:0] addr_arr  [N_REQ];
  logic [DATA_W-1:0] wdata_arr [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign addr_arr[gi]  = bus.req_addr[gi*ADDR_W +: ADDR_W];
    assign wdata_arr[gi] = bus.req_wdata[gi*DATA_W +: DATA_W];
  end

`ifdef IOB_SP_RAM_ARB_FIXED_PRIO_EN
  assign arb_ptr = '0;
`else
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  assign arb_ptr = rr_ptr_q;
`endif

  iob_rr_arb #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req       (bus.req_valid),
    .ptr       (arb_ptr),
    .gnt_oh    (gnt_oh),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    we_d         = we_q;
    ready_d      = '0;
    rdata_d      = rdata_q;
`ifndef IOB_SP_RAM_ARB_FIXED_PRIO_EN
    rr_ptr_d     = rr_ptr_q;
`endif
    bus.ram_en   = 1'b0;
    bus.ram_we   = 1'b0;
    bus.ram_addr = addr_arr[gnt_idx];
    bus.ram_din  = wdata_arr[gnt_idx];

    unique case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          bus.ram_en = 1'b1;
          bus.ram_we = |(bus.req_we & gnt_oh);
          grant_d    = gnt_idx;
          we_d       = |(bus.req_we & gnt_oh);
          state_d    = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // RAM read data is valid now; a write keeps the last returned value.
        ready_d[grant_d] = 1'b1;
        if (!we_q) begin
          rdata_d = bus.ram_dout;
        end
`ifndef IOB_SP_RAM_ARB_FIXED_PRIO_EN
        rr_ptr_d = (grant_q == IDX_W'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
`endif
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      we_q     <= 1'b0;
      ready_q  <= '0;
      rdata_q  <= '0;
`ifndef IOB_SP_RAM_ARB_FIXED_PRIO_EN
      rr_ptr_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      we_q     <= we_d;
      ready_q  <= ready_d;
      rdata_q  <= rdata_d;
`ifndef IOB_SP_RAM_ARB_FIXED_PRIO_EN
      rr_ptr_q <= rr_ptr_d;
`endif
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.req_rdata = rdata_q;

endmodule

// File: tb/tb_iob_sp_ram_arb.sv
// -----------------------------------------------------------------------------
// tb_iob_sp_ram_arb
// Self-checking bench for iob_sp_ram_arb with a behavioural single-port RAM.
// Expected completions are queued as stimulus is driven and popped when a
// req_ready pulse appears. Expectations follow the build: define
// IOB_SP_RAM_ARB_FIXED_PRIO_EN for both bench and RTL to check fixed priority.
// Inputs change 1 time unit after the rising edge; outputs are sampled later
// in the cycle.
// -----------------------------------------------------------------------------
module tb_iob_sp_ram_arb;

  localparam int N_REQ  = 2;
  localparam int ADDR_W = 14;
  localparam int DATA_W = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  iob_sp_ram_arb_if #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  iob_sp_ram_arb #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Behavioural single-port RAM with registered read.
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (bus.ram_en) begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
      else            bus.ram_dout      <= mem[bus.ram_addr];
    end
  end

  typedef struct {
    logic [N_REQ-1:0]  ready;
    logic [DATA_W-1:0] rdata;
    string             tag;
  } exp_t;

  typedef struct {
    int                r;
    bit                we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
  } vec_t;

  exp_t              sb [$];
  exp_t              cur;
  vec_t              vecs [8];
  int                n_vec = 0;
  int                n_err = 0;
  logic [DATA_W-1:0] last_rdata = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Queue one completion in the order the arbiter is expected to finish it.
  task automatic expect_txn(input int r, input bit we, input logic [DATA_W-1:0] rd,
                            input string tag);
    exp_t e;
    if (!we) last_rdata = rd;
    e.ready = N_REQ'(1) << r;
    e.rdata = last_rdata;
    e.tag   = tag;
    sb.push_back(e);
  endtask

  // Completion monitor: every ready pulse must match the head of the queue.
  always @(negedge clk) begin
    if (bus.req_ready != '0) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_ready: got ready=%b, required no pulse", bus.req_ready);
      end else begin
        cur = sb.pop_front();
        chk({cur.tag, "_ready"}, 32'(bus.req_ready), 32'(cur.ready));
        chk({cur.tag, "_rdata"}, 32'(bus.req_rdata), 32'(cur.rdata));
        $display("txn %s: ready=%b rdata=0x%02h", cur.tag, bus.req_ready, bus.req_rdata);
      end
    end
  end

  // One isolated access by requester r; valid is dropped as the ready pulse appears.
  task automatic do_access(input int idx, input vec_t v);
    @(posedge clk); #1;
    bus.req_valid = '0;
    bus.req_valid[v.r] = 1'b1;
    bus.req_we[v.r]    = v.we;
    bus.req_addr[v.r*ADDR_W +: ADDR_W]  = v.addr;
    bus.req_wdata[v.r*DATA_W +: DATA_W] = v.wdata;
    expect_txn(v.r, v.we, v.rdata, $sformatf("vec%0d", idx));
    #3;
    chk($sformatf("vec%0d_ram_en", idx),   32'(bus.ram_en),   32'd1);
    chk($sformatf("vec%0d_ram_we", idx),   32'(bus.ram_we),   32'(v.we));
    chk($sformatf("vec%0d_ram_addr", idx), 32'(bus.ram_addr), 32'(v.addr));
    if (v.we) chk($sformatf("vec%0d_ram_din", idx), 32'(bus.ram_din), 32'(v.wdata));
    @(posedge clk); #4;
    chk($sformatf("vec%0d_busy_en", idx), 32'(bus.ram_en), 32'd0);
    @(posedge clk); #1;
    bus.req_valid = '0;
    #3;
    chk($sformatf("vec%0d_after_en", idx), 32'(bus.ram_en), 32'd0);
  endtask

  // Both requesters read (0 -> 0x001, 1 -> 0x002) with valid held for n accesses.
  // Optionally releases reset on the same step that raises the valids.
  task automatic contend(input int n, input bit release_rst, input string name);
    int               r;
    logic [ADDR_W-1:0] a;
    @(posedge clk); #1;
    if (release_rst) reset = 1'b0;
    bus.req_we    = '0;
    bus.req_addr  = {ADDR_W'(14'h002), ADDR_W'(14'h001)};
    bus.req_valid = '1;
    for (int k = 0; k < n; k++) begin
`ifdef IOB_SP_RAM_ARB_FIXED_PRIO_EN
      r = 0;
`else
      r = k % 2;
`endif
      expect_txn(r, 1'b0, (r == 0) ? 8'h11 : 8'h22, $sformatf("%s%0d_req%0d", name, k, r));
    end
    for (int k = 0; k < n; k++) begin
`ifdef IOB_SP_RAM_ARB_FIXED_PRIO_EN
      a = 14'h001;
`else
      a = (k % 2 == 0) ? 14'h001 : 14'h002;
`endif
      #3;
      chk($sformatf("%s%0d_ram_en", name, k),   32'(bus.ram_en),   32'd1);
      chk($sformatf("%s%0d_ram_we", name, k),   32'(bus.ram_we),   32'd0);
      chk($sformatf("%s%0d_ram_addr", name, k), 32'(bus.ram_addr), 32'(a));
      @(posedge clk); #4;
      chk($sformatf("%s%0d_busy_en", name, k), 32'(bus.ram_en), 32'd0);
      @(posedge clk); #1;
      if (k == n - 1) bus.req_valid = '0;
    end
    #3;
    chk({name, "_end_en"}, 32'(bus.ram_en), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, required finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{r: 0, we: 1'b0, addr: 14'h0010, wdata: 8'h00, rdata: 8'hA5};
    vecs[1] = '{r: 1, we: 1'b1, addr: 14'h1FFF, wdata: 8'h3C, rdata: 8'h00};
    vecs[2] = '{r: 1, we: 1'b0, addr: 14'h1FFF, wdata: 8'h00, rdata: 8'h3C};
    vecs[3] = '{r: 0, we: 1'b1, addr: 14'h0005, wdata: 8'h5A, rdata: 8'h00};
    vecs[4] = '{r: 1, we: 1'b0, addr: 14'h0005, wdata: 8'h00, rdata: 8'h5A};
    vecs[5] = '{r: 0, we: 1'b0, addr: 14'h3FFF, wdata: 8'h00, rdata: 8'h77};
    vecs[6] = '{r: 1, we: 1'b1, addr: 14'h0000, wdata: 8'hFF, rdata: 8'h00};
    vecs[7] = '{r: 0, we: 1'b0, addr: 14'h0000, wdata: 8'h00, rdata: 8'hFF};

    mem[14'h0010] = 8'hA5;
    mem[14'h0001] = 8'h11;
    mem[14'h0002] = 8'h22;
    mem[14'h3FFF] = 8'h77;
    mem[14'h1FFF] = 8'hEE;
    mem[14'h0005] = 8'h00;
    mem[14'h0000] = 8'h00;

    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #4;
    chk("rst_ready",  32'(bus.req_ready), 32'd0);
    chk("rst_rdata",  32'(bus.req_rdata), 32'd0);
    chk("rst_ram_en", 32'(bus.ram_en),    32'd0);

    // Both requesters valid straight out of reset.
    last_rdata = '0;
    contend(4, 1'b1, "cont");

    // Table of isolated single-requester accesses.
    for (int i = 0; i < 8; i++) do_access(i, vecs[i]);

    // Reset during the BUSY cycle of a requester 1 read: no completion,
    // and the pointer (left at 1 by the last table access) returns to 0.
    @(posedge clk); #1;
    bus.req_valid    = 2'b10;
    bus.req_we       = '0;
    bus.req_addr     = {ADDR_W'(14'h002), ADDR_W'(14'h001)};
    #3;
    chk("abort_ram_en", 32'(bus.ram_en), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = '0;
    last_rdata    = '0;
    #3;
    chk("abort_ready", 32'(bus.req_ready), 32'd0);
    chk("abort_rdata", 32'(bus.req_rdata), 32'd0);
    contend(2, 1'b1, "post_rst");

    // Idle window.
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #4;
      chk($sformatf("idle%0d_ram_en", i), 32'(bus.ram_en),    32'd0);
      chk($sformatf("idle%0d_ready", i),  32'(bus.req_ready), 32'd0);
    end

    chk("scoreboard_left", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
